// File: rtl/efuse_pkg.sv
// Shared types and constants for the eFuse macro responder.
package efuse_pkg;

  localparam int EFUSE_BITS  = 256;
  localparam int EFUSE_BYTES = 32;
  localparam int VIOL_W      = 5;
  localparam int HLEN_W      = 10;
  localparam int LCNT_W      = 4;

  localparam int VIOL_CONFLICT = 0;
  localparam int VIOL_NOEN     = 1;
  localparam int VIOL_ADDR     = 2;
  localparam int VIOL_SHORT    = 3;
  localparam int VIOL_LOW      = 4;

  typedef enum logic [2:0] {IDLE, RD_EN, RD_PULSE, PG_EN, PG_PULSE} rsp_state_t;

  // Byte indices past the array read back as zero.
  function automatic logic [7:0] fuse_byte(input logic [EFUSE_BITS-1:0] bits,
                                           input logic [7:0]            idx);
    logic [7:0] b;
    b = 8'h00;
    if (idx[7:5] == 3'd0) b = bits[{idx[4:0], 3'b000} +: 8];
    return b;
  endfunction

endpackage

// File: rtl/efuse_pulse_meter.sv
// aen edge detection plus saturating high-length and low-length counters.
module efuse_pulse_meter
  import efuse_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              aen_i,
  input  logic              restart_i,
  output logic              rise_o,
  output logic              fall_o,
  output logic [HLEN_W-1:0] hlen_o,
  output logic [LCNT_W-1:0] lcnt_o
);

  logic              aen_q;
  logic [HLEN_W-1:0] hlen_q, hlen_d, hlen_inc;
  logic [LCNT_W-1:0] lcnt_q, lcnt_d;

  assign rise_o = aen_i & ~aen_q;
  assign fall_o = ~aen_i & aen_q;

  // hlen_o counts the current high cycle; on the fall cycle it holds the pulse length.
  always_comb begin
    hlen_inc = rise_o ? HLEN_W'(1) : ((&hlen_q) ? hlen_q : hlen_q + 1'b1);
    hlen_d   = aen_i ? hlen_inc : hlen_q;
    lcnt_d   = lcnt_q;
    if (aen_i)                    lcnt_d = '0;
    else if (fall_o || restart_i) lcnt_d = LCNT_W'(1);
    else if (!(&lcnt_q))          lcnt_d = lcnt_q + 1'b1;
  end

  assign hlen_o = aen_i ? hlen_inc : hlen_q;
  assign lcnt_o = lcnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aen_q  <= 1'b0;
      hlen_q <= '0;
      lcnt_q <= '0;
    end else begin
      aen_q  <= aen_i;
      hlen_q <= hlen_d;
      lcnt_q <= lcnt_d;
    end
  end

endmodule

// File: rtl/efuse_macro_rsp.sv
// Cycle-accurate responder for the 256-bit eFuse macro interface.
// Define EFUSE_RSP_BLOW_CNT_EN to build the newly-blown-bit counter; otherwise blow_cnt is 0.
//   state    | meaning
//   IDLE     | no enable, or pgmen/rden conflict
//   RD_EN    | read mode, waiting for aen rise
//   RD_PULSE | read strobe high
//   PG_EN    | program mode, waiting for aen rise
//   PG_PULSE | program strobe high
module efuse_macro_rsp
  import efuse_pkg::*;
#(
  parameter int unsigned            TRD_MIN  = 3,
  parameter int unsigned            TPGM_MIN = 8,
  parameter int unsigned            TLOW_MIN = 2,
  parameter logic [EFUSE_BITS-1:0]  INIT_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  efuse_pgmen,
  input  logic                  efuse_rden,
  input  logic                  efuse_aen,
  input  logic [7:0]            efuse_addr,
  output logic [7:0]            efuse_d,
  output logic [EFUSE_BITS-1:0] fuse_bits,
  output logic [VIOL_W-1:0]     viol,
  input  logic                  viol_clr,
  output logic [8:0]            blow_cnt
);

  localparam logic [HLEN_W-1:0] TRD_VALID = HLEN_W'(TRD_MIN);
  localparam logic [HLEN_W-1:0] TRD_OK    = HLEN_W'(TRD_MIN + 1);
  localparam logic [HLEN_W-1:0] TPGM_OK   = HLEN_W'(TPGM_MIN);
  localparam logic [LCNT_W-1:0] TLOW_OK   = LCNT_W'(TLOW_MIN);

  rsp_state_t            state_q, state_d;
  logic [7:0]            addr_q, addr_d, rd_addr;
  logic                  addr_bad_q, addr_bad_d;
  logic                  low_bad_q, low_bad_d;
  logic [7:0]            d_q, d_d;
  logic [EFUSE_BITS-1:0] fuse_q, fuse_d;
  logic [VIOL_W-1:0]     viol_q, viol_d, viol_set;
  logic                  blow, conflict, in_pulse;
  logic                  rise, fall;
  logic [HLEN_W-1:0]     hlen;
  logic [LCNT_W-1:0]     lcnt;

  efuse_pulse_meter u_meter (
    .clk       (clk),
    .rst_n     (rst_n),
    .aen_i     (efuse_aen),
    .restart_i (state_q == IDLE),
    .rise_o    (rise),
    .fall_o    (fall),
    .hlen_o    (hlen),
    .lcnt_o    (lcnt)
  );

  assign conflict = efuse_pgmen & efuse_rden;
  assign in_pulse = (state_q == RD_PULSE) || (state_q == PG_PULSE);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    addr_bad_d = addr_bad_q;
    low_bad_d  = low_bad_q;
    viol_set   = '0;
    blow       = 1'b0;

    if (conflict) viol_set[VIOL_CONFLICT] = 1'b1;
    if (efuse_aen && !efuse_pgmen && !efuse_rden) viol_set[VIOL_NOEN] = 1'b1;
    if (in_pulse && efuse_aen && (efuse_addr != addr_q)) begin
      viol_set[VIOL_ADDR] = 1'b1;
      addr_bad_d          = 1'b1;
    end

    if (conflict) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (efuse_rden)       state_d = RD_EN;
          else if (efuse_pgmen) state_d = PG_EN;
        end
        RD_EN, PG_EN: begin
          if ((state_q == RD_EN) ? !efuse_rden : !efuse_pgmen) begin
            state_d = IDLE;
          end else if (rise) begin
            state_d    = (state_q == RD_EN) ? RD_PULSE : PG_PULSE;
            addr_d     = efuse_addr;
            addr_bad_d = 1'b0;
            low_bad_d  = (lcnt < TLOW_OK);
            if (lcnt < TLOW_OK) viol_set[VIOL_LOW] = 1'b1;
          end
        end
        RD_PULSE: begin
          if (!efuse_rden) begin
            state_d              = IDLE;
            viol_set[VIOL_SHORT] = 1'b1;
          end else if (fall) begin
            state_d = RD_EN;
            if (hlen < TRD_OK) viol_set[VIOL_SHORT] = 1'b1;
          end
        end
        PG_PULSE: begin
          if (!efuse_pgmen) begin
            state_d              = IDLE;
            viol_set[VIOL_SHORT] = 1'b1;
          end else if (fall) begin
            state_d = PG_EN;
            if (hlen < TPGM_OK)               viol_set[VIOL_SHORT] = 1'b1;
            else if (!addr_bad_q && !low_bad_q) blow = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Read data follows the next state so it drops to zero as soon as the pulse ends or aborts.
  always_comb begin
    rd_addr = rise ? efuse_addr : addr_q;
    d_d     = 8'h00;
    if ((state_d == RD_PULSE) && (hlen >= TRD_VALID)) d_d = fuse_byte(fuse_q, rd_addr);
  end

  always_comb begin
    fuse_d = fuse_q;
    if (blow) fuse_d[addr_q] = 1'b1;
    viol_d = (viol_clr ? '0 : viol_q) | viol_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      addr_bad_q <= 1'b0;
      low_bad_q  <= 1'b0;
      d_q        <= '0;
      fuse_q     <= INIT_VAL;
      viol_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      addr_bad_q <= addr_bad_d;
      low_bad_q  <= low_bad_d;
      d_q        <= d_d;
      fuse_q     <= fuse_d;
      viol_q     <= viol_d;
    end
  end

`ifdef EFUSE_RSP_BLOW_CNT_EN
  logic [8:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (blow && !fuse_q[addr_q] && (cnt_q != 9'd256)) cnt_d = cnt_q + 9'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign blow_cnt = cnt_q;
`else
  assign blow_cnt = 9'd0;
`endif

  assign efuse_d   = d_q;
  assign fuse_bits = fuse_q;
  assign viol      = viol_q;

endmodule

// File: tb/tb_efuse_macro_rsp.sv
// Self-checking bench for efuse_macro_rsp: directed protocol cases plus randomized pulses vs a fuse-array model.
module tb_efuse_macro_rsp;

  localparam int TRD_MIN  = 3;
  localparam int TPGM_MIN = 8;
  localparam int TLOW_MIN = 2;
  localparam logic [255:0] INIT = (256'hA5 << 24) | (256'h3C << 160) | (256'h5A << 232);

  logic         clk, rst_n;
  logic         efuse_pgmen, efuse_rden, efuse_aen, viol_clr;
  logic [7:0]   efuse_addr, efuse_d;
  logic [255:0] fuse_bits;
  logic [4:0]   viol;
  logic [8:0]   blow_cnt;

  int checks, errors;

  logic [255:0] m_fuse;
  logic [4:0]   m_viol;
  int           m_cnt;
  int           low_run;

  efuse_macro_rsp #(
    .TRD_MIN  (TRD_MIN),
    .TPGM_MIN (TPGM_MIN),
    .TLOW_MIN (TLOW_MIN),
    .INIT_VAL (INIT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .efuse_pgmen (efuse_pgmen),
    .efuse_rden  (efuse_rden),
    .efuse_aen   (efuse_aen),
    .efuse_addr  (efuse_addr),
    .efuse_d     (efuse_d),
    .fuse_bits   (fuse_bits),
    .viol        (viol),
    .viol_clr    (viol_clr),
    .blow_cnt    (blow_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] exp_cnt();
`ifdef EFUSE_RSP_BLOW_CNT_EN
    return 9'(m_cnt);
`else
    return 9'd0;
`endif
  endfunction

  function automatic logic [7:0] m_byte(input logic [7:0] a);
    return (a < 8'd32) ? m_fuse[int'(a)*8 +: 8] : 8'h00;
  endfunction

  // One clock; the model applies the cycle-level rules to the inputs that edge sampled.
  task automatic tick();
    @(posedge clk); #1;
    if (viol_clr) m_viol = '0;
    if (efuse_pgmen && efuse_rden) m_viol[0] = 1'b1;
    if (efuse_aen && !efuse_pgmen && !efuse_rden) m_viol[1] = 1'b1;
    if (!(efuse_pgmen ^ efuse_rden) || efuse_aen) low_run = 0;
    else low_run++;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_d"},    efuse_d,   8'h00);
    chk({tag, "_fuse"}, fuse_bits, m_fuse);
    chk({tag, "_viol"}, viol,      m_viol);
    chk({tag, "_cnt"},  blow_cnt,  exp_cnt());
  endtask

  task automatic enable(input bit rd, input bit pg, input int lo);
    efuse_aen = 1'b0; efuse_rden = 1'b0; efuse_pgmen = 1'b0;
    tick();
    efuse_rden = rd; efuse_pgmen = pg;
    repeat (lo) tick();
  endtask

  task automatic clr();
    viol_clr = 1'b1;
    tick();
    viol_clr = 1'b0;
    chk("clr_viol", viol, m_viol);
  endtask

  task automatic pulse(input bit prog, input logic [7:0] a, input int hi,
                       input int chg_at, input logic [7:0] a2, input int lo_after);
    int         rise_low;
    bit         chg;
    logic [7:0] exp_byte;
    efuse_addr = a;
    rise_low   = low_run;
    chg        = 1'b0;
    exp_byte   = m_byte(a);
    efuse_aen  = 1'b1;
    for (int k = 1; k <= hi; k++) begin
      if (!prog) chk("rd_d", efuse_d, (k > TRD_MIN) ? exp_byte : 8'h00);
      if (k == chg_at) begin
        efuse_addr = a2;
        chg        = 1'b1;
      end
      tick();
    end
    efuse_aen = 1'b0;
    if (!prog) chk("rd_tail", efuse_d, (hi >= TRD_MIN) ? exp_byte : 8'h00);
    tick();
    if (rise_low < TLOW_MIN) m_viol[4] = 1'b1;
    if (chg) m_viol[2] = 1'b1;
    if (prog) begin
      if (hi < TPGM_MIN) m_viol[3] = 1'b1;
      else if (!chg && rise_low >= TLOW_MIN) begin
        if (!m_fuse[a]) m_cnt++;
        m_fuse[a] = 1'b1;
      end
    end else if (hi < TRD_MIN + 1) begin
      m_viol[3] = 1'b1;
    end
    check_all(prog ? "pg" : "rd");
    repeat (lo_after - 1) tick();
  endtask

  initial begin
    int         hi, chg, lo;
    bit         pg;
    logic [7:0] a, a2;

    checks = 0; errors = 0;
    efuse_pgmen = 0; efuse_rden = 0; efuse_aen = 0; efuse_addr = 0; viol_clr = 0;
    m_fuse = INIT; m_viol = '0; m_cnt = 0; low_run = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;
    tick();

    // read byte 3 with a minimum-length pulse
    enable(1, 0, 2);
    pulse(0, 8'd3, 4, 0, 8'd0, 2);
    chk("t1_viol", viol, 5'b00000);

    // program bit 77, then re-blow it
    enable(0, 1, 2);
    pulse(1, 8'd77, 8, 0, 8'd0, 2);
    chk("t2_bit77", fuse_bits[77], 1'b1);
    pulse(1, 8'd77, 8, 0, 8'd0, 2);

    // one cycle short of a blow
    pulse(1, 8'd5, 7, 0, 8'd0, 2);
    chk("t3_viol", viol, 5'b01000);

    // address moves mid-pulse
    clr();
    pulse(1, 8'd10, 10, 3, 8'd11, 2);
    chk("t4_viol2", viol[2], 1'b1);
    chk("t4_bits", fuse_bits[11:10], 2'b00);
    clr();
    chk("t4_clr", viol, 5'b00000);

    // strobe without any enable
    enable(0, 0, 1);
    efuse_aen = 1'b1;
    tick();
    efuse_aen = 1'b0;
    tick();
    check_all("noen");
    clr();

    // conflict, with a clear colliding with the ongoing violation
    enable(1, 1, 2);
    efuse_addr = 8'd20;
    efuse_aen  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("conf_d", efuse_d, 8'h00);
      viol_clr = (k == 4);
      tick();
    end
    viol_clr  = 1'b0;
    efuse_aen = 1'b0;
    tick();
    check_all("conf");
    chk("conf_viol", viol, 5'b00001);
    enable(0, 0, 1);
    clr();

    // randomized sessions of reads and programs
    for (int i = 0; i < 30; i++) begin
      pg = 1'($urandom_range(0, 1));
      enable(!pg, pg, $urandom_range(1, 3));
      repeat (2) begin
        hi  = pg ? $urandom_range(6, 11) : $urandom_range(2, 6);
        a   = pg ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 39));
        chg = ($urandom_range(0, 7) == 0) ? $urandom_range(2, hi) : 0;
        a2  = a ^ 8'($urandom_range(1, 255));
        lo  = $urandom_range(1, 3);
        pulse(pg, a, hi, chg, a2, lo);
      end
      if ($urandom_range(0, 3) == 0) clr();
    end

    // reset during the 5th high cycle of a program pulse
    enable(0, 1, 2);
    efuse_addr = 8'd200;
    efuse_aen  = 1'b1;
    repeat (4) tick();
    rst_n = 1'b0;
    m_fuse = INIT; m_viol = '0; m_cnt = 0; low_run = 0;
    #2;
    check_all("rst_mid");
    efuse_aen = 1'b0; efuse_pgmen = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check_all("rst_after");

    // program 64'h8000_0000_0000_0001 and read the low eight bytes back
    enable(0, 1, 2);
    pulse(1, 8'd0, 8, 0, 8'd0, 2);
    pulse(1, 8'd63, 8, 0, 8'd0, 2);
    chk("ctl_bit0", fuse_bits[0], 1'b1);
    chk("ctl_bit63", fuse_bits[63], 1'b1);
    enable(1, 0, 2);
    for (int b = 0; b < 8; b++) pulse(0, 8'(b), 4, 0, 8'd0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
